pc_fetch_ctrl: RTL

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_if.sv | 36 +++
 rtl/pc_fetch_ctrl.sv | 92 +++++++++
 2 files changed

// File: rtl/pc_fetch_if.sv
// Fetch-controller bus: PC adder, instruction memory and decode handshake signals.
// Optional AlignErr member appears only when PC_ALIGN_CHECK_EN is defined.
interface pc_fetch_if;
    logic [31:0] PCAddResult;
    logic [31:0] PCResult;
    logic        Redirect;
    logic [31:0] RedirectAddr;
    logic        IMemReq;
    logic        IMemAck;
    logic [31:0] IMemData;
    logic        InstrValid;
    logic [31:0] Instruction;
    logic [31:0] InstrPC;
    logic        InstrReady;
`ifdef PC_ALIGN_CHECK_EN
    logic        AlignErr;

    modport master (
        input  PCAddResult, Redirect, RedirectAddr, IMemAck, IMemData, InstrReady,
        output PCResult, IMemReq, InstrValid, Instruction, InstrPC, AlignErr
    );
    modport slave (
        output PCAddResult, Redirect, RedirectAddr, IMemAck, IMemData, InstrReady,
        input  PCResult, IMemReq, InstrValid, Instruction, InstrPC, AlignErr
    );
`else
    modport master (
        input  PCAddResult, Redirect, RedirectAddr, IMemAck, IMemData, InstrReady,
        output PCResult, IMemReq, InstrValid, Instruction, InstrPC
    );
    modport slave (
        output PCAddResult, Redirect, RedirectAddr, IMemAck, IMemData, InstrReady,
        input  PCResult, IMemReq, InstrValid, Instruction, InstrPC
    );
`endif
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program-counter fetch controller: IDLE -> REQ (memory request) -> HOLD (instruction to decode).
// Define PC_ALIGN_CHECK_EN to reject misaligned redirect targets and raise sticky AlignErr.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic       Clk,
    input  logic       Reset,
    pc_fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_pc, w_pc_next;
    logic [31:0] r_instr, w_instr_next;
    logic [31:0] r_instr_pc, w_instr_pc_next;
    logic        w_target_ok;

`ifdef PC_ALIGN_CHECK_EN
    logic r_align_err, w_align_err_next;
    assign w_target_ok  = (bus.RedirectAddr[1:0] == 2'b00);
    assign bus.AlignErr = r_align_err;
`else
    assign w_target_ok  = 1'b1;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_instr    <= 32'h0;
            r_instr_pc <= 32'h0;
`ifdef PC_ALIGN_CHECK_EN
            r_align_err <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_instr    <= w_instr_next;
            r_instr_pc <= w_instr_pc_next;
`ifdef PC_ALIGN_CHECK_EN
            r_align_err <= w_align_err_next;
`endif
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_instr_next    = r_instr;
        w_instr_pc_next = r_instr_pc;
`ifdef PC_ALIGN_CHECK_EN
        w_align_err_next = r_align_err;
`endif
        case (r_state)
            IDLE: w_state_next = REQ;
            REQ: begin
                // A redirect in the same cycle discards the returned data.
                if (bus.IMemAck && !bus.Redirect) begin
                    w_instr_next    = bus.IMemData;
                    w_instr_pc_next = r_pc;
                    w_pc_next       = bus.PCAddResult;
                    w_state_next    = HOLD;
                end
            end
            HOLD: begin
                if (bus.InstrReady) begin
                    w_state_next = REQ;
                end
            end
            default: w_state_next = IDLE;
        endcase

        // Redirect overrides every other event, in any state.
        if (bus.Redirect) begin
            w_state_next = REQ;
            if (w_target_ok) begin
                w_pc_next = bus.RedirectAddr;
            end
`ifdef PC_ALIGN_CHECK_EN
            else begin
                w_align_err_next = 1'b1;
            end
`endif
        end
    end

    assign bus.IMemReq     = (r_state == REQ);
    assign bus.InstrValid  = (r_state == HOLD);
    assign bus.PCResult    = r_pc;
    assign bus.Instruction = r_instr;
    assign bus.InstrPC     = r_instr_pc;
endmodule
